pulse_cmd_fifo: RTL and testbench

- Captures complete pulse commands issued by the processor core on each cstrobe and buffers them in a FIFO.
- Presents them to the downstream DSP element (waveform/envelope generator) over a valid/ready handshake.
- Decouples processor issue timing from element back-pressure.
- Reports occupancy and latches a sticky overflow flag when a command is dropped.

---
 rtl/pulse_cmd_fifo.sv | 115 +++++++++++
 tb/tb_pulse_cmd_fifo.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/pulse_cmd_fifo.sv
// pulse_cmd_fifo: buffers complete pulse commands issued by the processor
// on cstrobe_in and hands them to the downstream DSP element over a
// valid/ready handshake. Reports occupancy and a sticky overflow flag
// whenever a command has to be dropped because the buffer is full.
module pulse_cmd_fifo #(
  parameter int PHASE_WIDTH    = 17,
  parameter int FREQ_WIDTH     = 9,
  parameter int AMP_WIDTH      = 16,
  parameter int CFG_WIDTH      = 4,
  parameter int ENV_WORD_WIDTH = 24,
  parameter int DEPTH          = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [PHASE_WIDTH-1:0]     phase_in,
  input  logic [FREQ_WIDTH-1:0]      freq_in,
  input  logic [AMP_WIDTH-1:0]       amp_in,
  input  logic [ENV_WORD_WIDTH-1:0]  env_word_in,
  input  logic [CFG_WIDTH-1:0]       cfg_in,
  input  logic                       cstrobe_in,
  output logic [PHASE_WIDTH-1:0]     phase_out,
  output logic [FREQ_WIDTH-1:0]      freq_out,
  output logic [AMP_WIDTH-1:0]       amp_out,
  output logic [ENV_WORD_WIDTH-1:0]  env_word_out,
  output logic [CFG_WIDTH-1:0]       cfg_out,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       overflow,
  input  logic                       overflow_clr
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = CFG_WIDTH + ENV_WORD_WIDTH + AMP_WIDTH + FREQ_WIDTH + PHASE_WIDTH;

  // Command storage; contents are don't-care after reset, so no reset here.
  logic [ENTRY_W-1:0] mem [DEPTH];

  logic [PTR_W-1:0]   wr_ptr_reg;
  logic [PTR_W-1:0]   rd_ptr_reg;
  logic [CNT_W-1:0]   count_reg;
  logic               overflow_reg;

  logic [ENTRY_W-1:0] entry_in;
  logic [ENTRY_W-1:0] head_data;
  logic               push;
  logic               pop;
  logic               drop;

  // Field order inside an entry: {cfg, env_word, amp, freq, phase}.
  assign entry_in = {cfg_in, env_word_in, amp_in, freq_in, phase_in};

  // Status flags come from the registered count only, so reset clears
  // out_valid asynchronously along with the count.
  assign out_valid = (count_reg != '0);
  assign full      = (count_reg == CNT_W'(DEPTH));

  // A pop at the same edge frees a slot, so a full FIFO can still accept
  // a strobe when the head is being consumed.
  assign pop  = out_valid & out_ready;
  assign push = cstrobe_in & (~full | pop);
  assign drop = cstrobe_in & full & ~pop;

  // Head entry is forced to zero whenever nothing is buffered.
  assign head_data = out_valid ? mem[rd_ptr_reg] : '0;
  assign {cfg_out, env_word_out, amp_out, freq_out, phase_out} = head_data;

  assign count    = count_reg;
  assign overflow = overflow_reg;

  // Write an accepted command into the slot addressed by the write pointer.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= entry_in;
    end
  end

  // Pointers advance on push/pop and wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  // Occupancy tracks push minus pop; simultaneous push and pop cancel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else begin
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Sticky overflow: a dropped command sets it and wins over a clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_reg <= 1'b0;
    end else if (drop) begin
      overflow_reg <= 1'b1;
    end else if (overflow_clr) begin
      overflow_reg <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pulse_cmd_fifo.sv
// Directed bench for pulse_cmd_fifo: reset state, single command latency,
// fill/drain order, overflow set/clear priority, full push+pop, streaming
// with pointer wrap, and asynchronous reset mid-stream.
module tb_pulse_cmd_fifo;

  localparam int PHASE_WIDTH    = 17;
  localparam int FREQ_WIDTH     = 9;
  localparam int AMP_WIDTH      = 16;
  localparam int CFG_WIDTH      = 4;
  localparam int ENV_WORD_WIDTH = 24;
  localparam int DEPTH          = 8;

  logic                       clk;
  logic                       reset;
  logic [PHASE_WIDTH-1:0]     phase_in;
  logic [FREQ_WIDTH-1:0]      freq_in;
  logic [AMP_WIDTH-1:0]       amp_in;
  logic [ENV_WORD_WIDTH-1:0]  env_word_in;
  logic [CFG_WIDTH-1:0]       cfg_in;
  logic                       cstrobe_in;
  logic [PHASE_WIDTH-1:0]     phase_out;
  logic [FREQ_WIDTH-1:0]      freq_out;
  logic [AMP_WIDTH-1:0]       amp_out;
  logic [ENV_WORD_WIDTH-1:0]  env_word_out;
  logic [CFG_WIDTH-1:0]       cfg_out;
  logic                       out_valid;
  logic                       out_ready;
  logic [$clog2(DEPTH):0]     count;
  logic                       full;
  logic                       overflow;
  logic                       overflow_clr;

  int checks;
  int failures;

  pulse_cmd_fifo #(
    .PHASE_WIDTH(PHASE_WIDTH), .FREQ_WIDTH(FREQ_WIDTH), .AMP_WIDTH(AMP_WIDTH),
    .CFG_WIDTH(CFG_WIDTH), .ENV_WORD_WIDTH(ENV_WORD_WIDTH), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset),
    .phase_in(phase_in), .freq_in(freq_in), .amp_in(amp_in),
    .env_word_in(env_word_in), .cfg_in(cfg_in), .cstrobe_in(cstrobe_in),
    .phase_out(phase_out), .freq_out(freq_out), .amp_out(amp_out),
    .env_word_out(env_word_out), .cfg_out(cfg_out),
    .out_valid(out_valid), .out_ready(out_ready),
    .count(count), .full(full), .overflow(overflow), .overflow_clr(overflow_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One line per comparison; failures are counted and reported.
  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) begin
      $display("check %s observed=%0h expected=%0h ok", tag, observed, expected);
    end else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance one clock edge, then settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    reset        = 1'b1;
    phase_in     = '0;
    freq_in      = '0;
    amp_in       = '0;
    env_word_in  = '0;
    cfg_in       = '0;
    cstrobe_in   = 1'b0;
    out_ready    = 1'b0;
    overflow_clr = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_phase", 32'(phase_out), 32'd0);
    reset = 1'b0;
    tick();

    // Single command, visible the cycle after the strobe edge
    phase_in    = 17'h1ABCD;
    freq_in     = 9'h1F3;
    amp_in      = 16'h7FFF;
    env_word_in = 24'h123456;
    cfg_in      = 4'h9;
    cstrobe_in  = 1'b1;
    out_ready   = 1'b1;
    tick();
    cstrobe_in = 1'b0;
    check("single_valid", 32'(out_valid), 32'd1);
    check("single_phase", 32'(phase_out), 32'h1ABCD);
    check("single_freq", 32'(freq_out), 32'h1F3);
    check("single_amp", 32'(amp_out), 32'h7FFF);
    check("single_env", 32'(env_word_out), 32'h123456);
    check("single_cfg", 32'(cfg_out), 32'h9);
    check("single_count", 32'(count), 32'd1);
    tick();
    check("single_after_valid", 32'(out_valid), 32'd0);
    check("single_after_count", 32'(count), 32'd0);
    check("single_after_phase", 32'(phase_out), 32'd0);

    // Fill with phase 0..7 under back-pressure
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      phase_in   = 17'(i);
      cstrobe_in = 1'b1;
      tick();
    end
    cstrobe_in = 1'b0;
    check("fill_count", 32'(count), 32'd8);
    check("fill_full", 32'(full), 32'd1);
    check("fill_ovf", 32'(overflow), 32'd0);
    check("fill_hold_phase", 32'(phase_out), 32'd0);

    // Ninth strobe with no pop is dropped
    phase_in   = 17'd99;
    cstrobe_in = 1'b1;
    tick();
    cstrobe_in = 1'b0;
    check("drop_ovf", 32'(overflow), 32'd1);
    check("drop_count", 32'(count), 32'd8);

    // Drop and clear at the same edge: set wins
    cstrobe_in   = 1'b1;
    overflow_clr = 1'b1;
    tick();
    cstrobe_in = 1'b0;
    check("clr_vs_drop_ovf", 32'(overflow), 32'd1);
    check("clr_vs_drop_count", 32'(count), 32'd8);

    // Clear alone
    tick();
    overflow_clr = 1'b0;
    check("clr_ovf", 32'(overflow), 32'd0);

    // Drain: 0..7 in order, then empty
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      check($sformatf("drain_valid%0d", i), 32'(out_valid), 32'd1);
      check($sformatf("drain_phase%0d", i), 32'(phase_out), 32'(i));
      tick();
    end
    check("drain_empty_valid", 32'(out_valid), 32'd0);
    check("drain_empty_count", 32'(count), 32'd0);

    // Full with push and pop on the same edge
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      phase_in   = 17'(10 + i);
      cstrobe_in = 1'b1;
      tick();
    end
    phase_in   = 17'd8;
    cstrobe_in = 1'b1;
    out_ready  = 1'b1;
    tick();
    cstrobe_in = 1'b0;
    check("fullpp_count", 32'(count), 32'd8);
    check("fullpp_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      check($sformatf("fullpp_phase%0d", i), 32'(phase_out), (i == DEPTH - 1) ? 32'd8 : 32'(11 + i));
      tick();
    end
    check("fullpp_empty", 32'(out_valid), 32'd0);

    // Streaming 20 commands: occupancy stays at 1
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      phase_in   = 17'(100 + i);
      cstrobe_in = 1'b1;
      tick();
      check($sformatf("stream_phase%0d", i), 32'(phase_out), 32'(100 + i));
      check($sformatf("stream_count%0d", i), 32'(count), 32'd1);
    end
    cstrobe_in = 1'b0;
    tick();
    check("stream_end_count", 32'(count), 32'd0);

    // Hold three entries, then assert reset between edges
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      phase_in   = 17'(200 + i);
      cstrobe_in = 1'b1;
      tick();
    end
    cstrobe_in = 1'b0;
    check("hold3_count", 32'(count), 32'd3);
    check("hold3_phase", 32'(phase_out), 32'd200);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_valid", 32'(out_valid), 32'd0);
    check("async_rst_count", 32'(count), 32'd0);
    check("async_rst_phase", 32'(phase_out), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    check("post_rst_valid", 32'(out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
